load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the execute stage and `DataMemory`. It accepts one load or store request at a time and checks its type, alignment and address window. It then drives `DataMemory`'s byte-lane interface for exactly one cycle and returns a sign- or zero-extended load result, or a fault, as a single-cycle response.

## Interface
Parameters:
- `ROM_BASE`, 32'h0010_0000: base of the read-only constants window.
- `ROM_SIZE`, 32'h0000_0100: ROM window size in bytes.
- `RAM_BASE`, 32'h8000_0000: base of the read/write window.
- `RAM_SIZE`, 32'h0000_1000: RAM window size in bytes.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_type`  in  3  RV32 funct3 code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  request was rejected.
- `resp_cause`  out  2  fault cause: 1 misaligned, 2 address range or write to ROM, 3 illegal type.
- `read_enable`, `write_enable`  out  1  memory strobes.
- `byte_sel`  out  4  memory byte lanes.
- `memory_addr`  out  32  word-aligned address (`req_addr & ~3`).
- `write_data`  out  32  lane-shifted store data.
- `read_data`  in  32  memory word, valid one cycle after `read_enable` is sampled.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid`, capture the request and classify it.
  - If it faults, go to RESP with no memory strobe.
  - Otherwise go to ISSUE.
- Fault priority: illegal type (011, 110, 111, or a store with 100/101) > misaligned (H with addr[0] set, W with addr[1:0] ≠ 0) > range.
- Range fault: the address is outside both windows, or a store targets ROM.
- ISSUE: assert `read_enable` (load) or `write_enable` (store), never both.
  - Next state: WAIT for a load, RESP for a store.
- WAIT: on the closing edge, extract the byte or half at offset addr[1:0] from `read_data`, extend it per `req_type`, and register it into `resp_rdata`. Next state RESP.
- RESP: `resp_valid` = 1 for one cycle, then IDLE. There is no backpressure.
- Lanes:
  - B: `byte_sel` = 0001 << addr[1:0]; `write_data` = wdata[7:0] << 8·addr[1:0].
  - H: `byte_sel` = 0011 << 2·addr[1]; `write_data` = wdata[15:0] << 16·addr[1].
  - W: `byte_sel` = 1111.
  - Unselected lanes are 0.
- All memory-side outputs are registered. Outside ISSUE they are 0: strobes, `byte_sel`, `write_data` and `memory_addr` all read 0.

## Timing
- Latency is counted from the accept edge to the cycle with `resp_valid` high:
  - load: 3 cycles;
  - store: 2 cycles;
  - fault: 1 cycle.
- Throughput: one request per latency plus 1 cycle, since `req_ready` is low in ISSUE, WAIT and RESP.
- Reset (asynchronous) forces:
  - state = IDLE;
  - all outputs = 0 except `req_ready` = 1 once the state is IDLE.
- Reset in ISSUE drops both strobes immediately, with no partial write guarantee beyond memory semantics. Reset in WAIT or RESP discards the response, and no `resp_valid` is emitted.
- `req_valid` seen outside IDLE is ignored. The requester must hold the request until `req_ready`.
- Window bounds are inclusive at the base and exclusive at base+size. The compare is unsigned with no wrap, so `RAM_BASE`+`RAM_SIZE` must not overflow 32 bits.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 localparams (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`);
  - the state encoding;
  - cause codes (`CAUSE_MISALIGN` = 1, `CAUSE_RANGE` = 2, `CAUSE_TYPE` = 3);
  - default window constants.
- Sub-module `lsu_align` is purely combinational. It performs the store lane shift, `byte_sel` generation, and load extract/extend. The top level holds the FSM, request registers and fault classifier.

## Test plan
- LW at 32'h0010_0004, memory returns 32'h1234_5678 → `read_enable` in ISSUE, `byte_sel` = 1111, `memory_addr` = 32'h0010_0004; `resp_rdata` = 32'h1234_5678 three cycles after accept, `resp_fault` = 0.
- SB at 32'h8000_0009 with wdata 32'hXXXX_XXA5 → `write_enable` for 1 cycle, `byte_sel` = 0010, `write_data` = 32'h0000_A500, `memory_addr` = 32'h8000_0008; `resp_valid` at cycle 2.
- LB / LBU at 32'h8000_000B, `read_data` = 32'h80FF_1234 → `resp_rdata` 32'hFFFF_FF80 / 32'h0000_0080. LH at offset 2 → 32'hFFFF_80FF.
- Faults:
  - LH at 32'h8000_0001 → cause 1.
  - SW to 32'h0010_0000 → cause 2.
  - LW at 32'h0000_000C → cause 2.
  - `req_type` 011 → cause 3.
  - In every fault case: no strobe ever asserted, response 1 cycle after accept.
- Reset asserted during WAIT of a load → outputs 0 immediately, no `resp_valid`; a subsequent LW completes normally.
- `req_valid` held high continuously with back-to-back requests → each accepted only in IDLE, and exactly one `resp_valid` per accepted request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM encoding,
// fault cause codes and default address windows.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE    = 2'd2;
  localparam logic [1:0] CAUSE_TYPE     = 2'd3;

  localparam logic [31:0] DEFAULT_ROM_BASE = 32'h0010_0000;
  localparam logic [31:0] DEFAULT_ROM_SIZE = 32'h0000_0100;
  localparam logic [31:0] DEFAULT_RAM_BASE = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_RAM_SIZE = 32'h0000_1000;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data shift and lane enables, plus load byte/half
// extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  lanes,
  output logic [31:0] store_lanes,
  output logic [31:0] load_result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val    = load_word[{offset, 3'b000} +: 8];
    half_val    = offset[1] ? load_word[31:16] : load_word[15:0];
    lanes       = 4'b0000;
    store_lanes = '0;
    load_result = '0;
    case (funct3)
      LSU_B, LSU_BU: begin
        lanes       = 4'b0001 << offset;
        store_lanes = {24'h0, store_data[7:0]} << {offset, 3'b000};
        load_result = (funct3 == LSU_B) ? {{24{byte_val[7]}}, byte_val}
                                        : {24'h0, byte_val};
      end
      LSU_H, LSU_HU: begin
        lanes       = 4'b0011 << {offset[1], 1'b0};
        store_lanes = {16'h0, store_data[15:0]} << {offset[1], 4'b0000};
        load_result = (funct3 == LSU_H) ? {{16{half_val[15]}}, half_val}
                                        : {16'h0, half_val};
      end
      LSU_W: begin
        lanes       = 4'b1111;
        store_lanes = store_data;
        load_result = load_word;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: classifies one load/store at a time, drives a single-cycle
// DataMemory access and returns an extended load result or a fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = DEFAULT_ROM_BASE,
  parameter logic [31:0] ROM_SIZE = DEFAULT_ROM_SIZE,
  parameter logic [31:0] RAM_BASE = DEFAULT_RAM_BASE,
  parameter logic [31:0] RAM_SIZE = DEFAULT_RAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic        read_enable,
  output logic        write_enable,
  output logic [3:0]  byte_sel,
  output logic [31:0] memory_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no ready.
  lsu_state_e state, next_state;

  logic        accept;
  logic        req_fault;
  logic [1:0]  req_cause;
  logic        type_bad, misaligned, in_rom, in_ram, range_bad;
  logic        write_q;
  logic [2:0]  type_q;
  logic [1:0]  offset_q;
  logic [2:0]  align_type;
  logic [1:0]  align_offset;
  logic [3:0]  align_lanes;
  logic [31:0] align_store, align_load;

  assign accept = (state == ST_IDLE) && req_valid;

  always_comb begin
    type_bad   = (req_type == 3'b011) || (req_type == 3'b110) || (req_type == 3'b111) ||
                 (req_write && ((req_type == LSU_BU) || (req_type == LSU_HU)));
    misaligned = (((req_type == LSU_H) || (req_type == LSU_HU)) && req_addr[0]) ||
                 ((req_type == LSU_W) && (req_addr[1:0] != 2'b00));
    in_rom     = (req_addr >= ROM_BASE) && (req_addr < ROM_BASE + ROM_SIZE);
    in_ram     = (req_addr >= RAM_BASE) && (req_addr < RAM_BASE + RAM_SIZE);
    range_bad  = !(in_rom || in_ram) || (req_write && in_rom);
    req_fault  = 1'b1;
    if (type_bad)        req_cause = CAUSE_TYPE;
    else if (misaligned) req_cause = CAUSE_MISALIGN;
    else if (range_bad)  req_cause = CAUSE_RANGE;
    else begin
      req_cause = CAUSE_NONE;
      req_fault = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (req_valid) next_state = req_fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: next_state = write_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
  end

  // In IDLE the aligner steers the incoming store; afterwards it extracts the
  // load using the captured type and offset.
  always_comb begin
    align_type   = (state == ST_IDLE) ? req_type       : type_q;
    align_offset = (state == ST_IDLE) ? req_addr[1:0]  : offset_q;
  end

  lsu_align u_align (
    .funct3      (align_type),
    .offset      (align_offset),
    .store_data  (req_wdata),
    .load_word   (read_data),
    .lanes       (align_lanes),
    .store_lanes (align_store),
    .load_result (align_load)
  );

  // Memory-side and response registers default to 0 each cycle so they are
  // only non-zero in the one cycle they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      byte_sel     <= 4'b0000;
      memory_addr  <= '0;
      write_data   <= '0;
      resp_rdata   <= '0;
      resp_fault   <= 1'b0;
      resp_cause   <= CAUSE_NONE;
      write_q      <= 1'b0;
      type_q       <= 3'b000;
      offset_q     <= 2'b00;
    end else begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      byte_sel     <= 4'b0000;
      memory_addr  <= '0;
      write_data   <= '0;
      resp_rdata   <= '0;
      resp_fault   <= 1'b0;
      resp_cause   <= CAUSE_NONE;
      if (accept) begin
        write_q  <= req_write;
        type_q   <= req_type;
        offset_q <= req_addr[1:0];
        if (req_fault) begin
          resp_fault <= 1'b1;
          resp_cause <= req_cause;
        end else begin
          read_enable  <= !req_write;
          write_enable <= req_write;
          byte_sel     <= align_lanes;
          memory_addr  <= {req_addr[31:2], 2'b00};
          write_data   <= req_write ? align_store : 32'h0;
        end
      end
      if (state == ST_WAIT) resp_rdata <= align_load;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, reset mid-access
// and back-to-back requests, with cycle-exact checks of memory and response signals.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        read_enable, write_enable;
  logic [3:0]  byte_sel;
  logic [31:0] memory_addr, write_data, read_data;

  int tests_run    = 0;
  int tests_failed = 0;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_type     (req_type),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .resp_cause   (resp_cause),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .byte_sel     (byte_sel),
    .memory_addr  (memory_addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue_req(input string tag, input logic wr, input logic [2:0] ty,
                           input logic [31:0] a, input logic [31:0] d);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_type  = ty;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] ty, input logic [31:0] a,
                          input logic [31:0] word, input logic [3:0] sel,
                          input logic [31:0] expv);
    issue_req(tag, 1'b0, ty, a, 32'h0);
    check({tag, "_issue_re"},    read_enable,  1);
    check({tag, "_issue_we"},    write_enable, 0);
    check({tag, "_issue_sel"},   byte_sel,     sel);
    check({tag, "_issue_addr"},  memory_addr,  a & 32'hFFFF_FFFC);
    check({tag, "_issue_ready"}, req_ready,    0);
    step();
    read_data = word;
    check({tag, "_wait_re"},    read_enable, 0);
    check({tag, "_wait_sel"},   byte_sel,    0);
    check({tag, "_wait_addr"},  memory_addr, 0);
    check({tag, "_wait_valid"}, resp_valid,  0);
    step();
    read_data = 32'hDEAD_BEEF;
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_rdata"}, resp_rdata, expv);
    check({tag, "_resp_fault"}, resp_fault, 0);
    step();
    check({tag, "_idle_valid"}, resp_valid, 0);
    check({tag, "_idle_rdata"}, resp_rdata, 0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] ty, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] sel,
                           input logic [31:0] wexp, input logic [31:0] aexp);
    issue_req(tag, 1'b1, ty, a, d);
    check({tag, "_issue_we"},    write_enable, 1);
    check({tag, "_issue_re"},    read_enable,  0);
    check({tag, "_issue_sel"},   byte_sel,     sel);
    check({tag, "_issue_wdata"}, write_data,   wexp);
    check({tag, "_issue_addr"},  memory_addr,  aexp);
    check({tag, "_issue_valid"}, resp_valid,   0);
    step();
    check({tag, "_resp_valid"}, resp_valid,   1);
    check({tag, "_resp_fault"}, resp_fault,   0);
    check({tag, "_resp_rdata"}, resp_rdata,   0);
    check({tag, "_resp_we"},    write_enable, 0);
    check({tag, "_resp_wdata"}, write_data,   0);
    step();
    check({tag, "_idle_valid"}, resp_valid, 0);
  endtask

  task automatic run_fault(input string tag, input logic wr, input logic [2:0] ty,
                           input logic [31:0] a, input logic [1:0] cause);
    issue_req(tag, wr, ty, a, 32'hFFFF_FFFF);
    check({tag, "_valid"}, resp_valid,   1);
    check({tag, "_fault"}, resp_fault,   1);
    check({tag, "_cause"}, resp_cause,   cause);
    check({tag, "_rdata"}, resp_rdata,   0);
    check({tag, "_re"},    read_enable,  0);
    check({tag, "_we"},    write_enable, 0);
    check({tag, "_sel"},   byte_sel,     0);
    step();
    check({tag, "_after_valid"}, resp_valid, 0);
    check({tag, "_after_fault"}, resp_fault, 0);
    check({tag, "_after_cause"}, resp_cause, 0);
    check({tag, "_after_ready"}, req_ready,  1);
  endtask

  initial begin
    int accepts, resps, reads;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_type  = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    read_data = 32'hDEAD_BEEF;
    #2;
    check("rst_ready", req_ready,    1);
    check("rst_valid", resp_valid,   0);
    check("rst_rdata", resp_rdata,   0);
    check("rst_fault", resp_fault,   0);
    check("rst_cause", resp_cause,   0);
    check("rst_re",    read_enable,  0);
    check("rst_we",    write_enable, 0);
    check("rst_sel",   byte_sel,     0);
    check("rst_addr",  memory_addr,  0);
    check("rst_wdata", write_data,   0);
    step();
    step();
    reset = 1'b0;
    step();

    // Loads
    run_load("lw_rom",      LSU_W,  32'h0010_0004, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    run_load("lw_rom_base", LSU_W,  32'h0010_0000, 32'hCAFE_0001, 4'b1111, 32'hCAFE_0001);
    run_load("lw_rom_last", LSU_W,  32'h0010_00FC, 32'h0F0E_0D0C, 4'b1111, 32'h0F0E_0D0C);
    run_load("lb_off3",     LSU_B,  32'h8000_000B, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    run_load("lbu_off3",    LSU_BU, 32'h8000_000B, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
    run_load("lb_off0",     LSU_B,  32'h8000_0008, 32'h80FF_1234, 4'b0001, 32'h0000_0034);
    run_load("lb_off1",     LSU_B,  32'h8000_0009, 32'h80FF_9234, 4'b0010, 32'hFFFF_FF92);
    run_load("lh_off2",     LSU_H,  32'h8000_000A, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
    run_load("lhu_off2",    LSU_HU, 32'h8000_000A, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
    run_load("lh_off0",     LSU_H,  32'h8000_0008, 32'h80FF_1234, 4'b0011, 32'h0000_1234);
    run_load("lw_ram_last", LSU_W,  32'h8000_0FFC, 32'hA5A5_5A5A, 4'b1111, 32'hA5A5_5A5A);

    // Stores
    run_store("sb_off1", LSU_B, 32'h8000_0009, 32'h1234_56A5, 4'b0010, 32'h0000_A500, 32'h8000_0008);
    run_store("sb_off0", LSU_B, 32'h8000_0010, 32'hFFFF_FF77, 4'b0001, 32'h0000_0077, 32'h8000_0010);
    run_store("sb_off3", LSU_B, 32'h8000_0013, 32'h0000_00C3, 4'b1000, 32'hC300_0000, 32'h8000_0010);
    run_store("sh_off2", LSU_H, 32'h8000_0006, 32'hFFFF_BEEF, 4'b1100, 32'hBEEF_0000, 32'h8000_0004);
    run_store("sh_off0", LSU_H, 32'h8000_0004, 32'h1111_2222, 4'b0011, 32'h0000_2222, 32'h8000_0004);
    run_store("sw_ram",  LSU_W, 32'h8000_00FC, 32'hA5A5_5A5A, 4'b1111, 32'hA5A5_5A5A, 32'h8000_00FC);

    // Faults and their priority
    run_fault("lh_misalign",   1'b0, LSU_H,  32'h8000_0001, CAUSE_MISALIGN);
    run_fault("lhu_misalign",  1'b0, LSU_HU, 32'h8000_0003, CAUSE_MISALIGN);
    run_fault("lw_misalign",   1'b0, LSU_W,  32'h8000_0002, CAUSE_MISALIGN);
    run_fault("sw_rom",        1'b1, LSU_W,  32'h0010_0000, CAUSE_RANGE);
    run_fault("lw_low",        1'b0, LSU_W,  32'h0000_000C, CAUSE_RANGE);
    run_fault("lw_rom_end",    1'b0, LSU_W,  32'h0010_0100, CAUSE_RANGE);
    run_fault("lw_ram_end",    1'b0, LSU_W,  32'h8000_1000, CAUSE_RANGE);
    run_fault("lb_below_ram",  1'b0, LSU_B,  32'h7FFF_FFFF, CAUSE_RANGE);
    run_fault("type_011",      1'b0, 3'b011, 32'h8000_0000, CAUSE_TYPE);
    run_fault("type_111",      1'b0, 3'b111, 32'h8000_0000, CAUSE_TYPE);
    run_fault("store_bu",      1'b1, LSU_BU, 32'h8000_0000, CAUSE_TYPE);
    run_fault("store_hu",      1'b1, LSU_HU, 32'h8000_0000, CAUSE_TYPE);
    run_fault("type_over_mis", 1'b0, 3'b110, 32'h0000_0001, CAUSE_TYPE);
    run_fault("mis_over_rng",  1'b0, LSU_W,  32'h0000_0002, CAUSE_MISALIGN);

    // Reset during WAIT discards the response
    issue_req("rst_wait", 1'b0, LSU_W, 32'h8000_0020, 32'h0);
    step();
    read_data = 32'h5555_AAAA;
    reset = 1'b1;
    #1;
    check("rst_wait_ready", req_ready,   1);
    check("rst_wait_valid", resp_valid,  0);
    check("rst_wait_rdata", resp_rdata,  0);
    check("rst_wait_re",    read_enable, 0);
    step();
    check("rst_wait_noresp", resp_valid, 0);
    reset = 1'b0;
    step();
    check("rst_wait_noresp2", resp_valid, 0);
    check("rst_wait_rdata2",  resp_rdata, 0);

    // Reset during ISSUE drops the strobe at once
    issue_req("rst_issue", 1'b1, LSU_W, 32'h8000_0040, 32'h1357_9BDF);
    check("rst_issue_we_before", write_enable, 1);
    reset = 1'b1;
    #1;
    check("rst_issue_we",    write_enable, 0);
    check("rst_issue_sel",   byte_sel,     0);
    check("rst_issue_addr",  memory_addr,  0);
    check("rst_issue_wdata", write_data,   0);
    step();
    reset = 1'b0;
    step();
    check("rst_issue_noresp", resp_valid, 0);

    run_load("lw_after_rst", LSU_W, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // req_valid held high: a load is accepted every 4 cycles
    accepts   = 0;
    resps     = 0;
    reads     = 0;
    read_data = 32'h0BAD_CAFE;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_type  = LSU_W;
    req_addr  = 32'h8000_0004;
    for (int i = 0; i < 16; i++) begin
      if (req_ready) accepts++;
      if (read_enable) reads++;
      if (resp_valid) begin
        resps++;
        check("b2b_rdata", resp_rdata, 32'h0BAD_CAFE);
      end
      step();
    end
    req_valid = 1'b0;
    check("b2b_accepts", accepts, 4);
    check("b2b_resps",   resps,   4);
    check("b2b_reads",   reads,   4);
    step();
    step();
    check("b2b_drain_valid", resp_valid, 0);
    check("b2b_drain_ready", req_ready,  1);

    // Mixed back-to-back: store then fault then load
    run_store("sw_b2b", LSU_W, 32'h8000_0100, 32'h0102_0304, 4'b1111, 32'h0102_0304, 32'h8000_0100);
    run_fault("f_b2b", 1'b0, LSU_H, 32'h8000_0105, CAUSE_MISALIGN);
    run_load("lbu_b2b", LSU_BU, 32'h8000_0101, 32'h0102_F304, 4'b0010, 32'h0000_00F3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
